// File: rtl/msrh_l2_req_router.sv
// msrh_l2_req_router: N-port request arbiter / response router in front of one L2 port.
// Request and response paths are combinational; arbitration pointer, grant lock,
// per-port outstanding-read counters and the sticky error flag are registered.
// The command encoding is a parameter so the block stands alone; M_XRD defaults
// to the LSU read encoding (any other value is treated as a write).

// Per-port bookkeeping: outstanding-read counter and read-cap eligibility.
module msrh_l2_req_router_lane #(
    parameter int MAX_OUTST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_is_rd,
    input  logic req_accept,
    input  logic resp_hs,
    output logic eligible,
    output logic underflow
);
    logic [3:0] outst;
    logic       inc;

    assign inc       = req_accept & req_is_rd;
    assign eligible  = req_valid & ~(req_is_rd & (outst == 4'(MAX_OUTST)));
    assign underflow = resp_hs & (outst == 4'd0);

    // Count reads in flight; a simultaneous issue and return cancels, 0 never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst <= '0;
        end else if (inc && !resp_hs) begin
            outst <= outst + 4'd1;
        end else if (!inc && resp_hs && (outst != 4'd0)) begin
            outst <= outst - 4'd1;
        end
    end
endmodule

module msrh_l2_req_router #(
    parameter int              REQ_PORTS = 3,
    parameter int              TAG_W     = 8,
    parameter int              ADDR_W    = 56,
    parameter int              DATA_W    = 256,
    parameter int              CMD_W     = 5,
    parameter logic [CMD_W-1:0] M_XRD    = '0,
    parameter int              ARB_MODE  = 0,
    parameter int              MAX_OUTST = 4,
    localparam int             PORT_W    = $clog2(REQ_PORTS)
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset_n,
    input  logic [REQ_PORTS-1:0]                  i_req_valid,
    input  logic [REQ_PORTS-1:0][CMD_W-1:0]       i_req_cmd,
    input  logic [REQ_PORTS-1:0][ADDR_W-1:0]      i_req_addr,
    input  logic [REQ_PORTS-1:0][TAG_W-1:0]       i_req_tag,
    input  logic [REQ_PORTS-1:0][DATA_W-1:0]      i_req_data,
    input  logic [REQ_PORTS-1:0][DATA_W/8-1:0]    i_req_byte_en,
    output logic [REQ_PORTS-1:0]                  o_req_ready,
    output logic [REQ_PORTS-1:0]                  o_resp_valid,
    output logic [TAG_W-1:0]                      o_resp_tag,
    output logic [DATA_W-1:0]                     o_resp_data,
    input  logic [REQ_PORTS-1:0]                  i_resp_ready,
    output logic                                  o_l2_req_valid,
    output logic [CMD_W-1:0]                      o_l2_req_cmd,
    output logic [ADDR_W-1:0]                     o_l2_req_addr,
    output logic [TAG_W+PORT_W-1:0]               o_l2_req_tag,
    output logic [DATA_W-1:0]                     o_l2_req_data,
    output logic [DATA_W/8-1:0]                   o_l2_req_byte_en,
    input  logic                                  i_l2_req_ready,
    input  logic                                  i_l2_resp_valid,
    input  logic [TAG_W+PORT_W-1:0]               i_l2_resp_tag,
    input  logic [DATA_W-1:0]                     i_l2_resp_data,
    output logic                                  o_l2_resp_ready,
    output logic                                  o_err
);
    typedef struct packed {
        logic [CMD_W-1:0]    cmd;
        logic [ADDR_W-1:0]   addr;
        logic [TAG_W-1:0]    tag;
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] byte_en;
    } req_t;

    logic [REQ_PORTS-1:0] elig, resp_hs, underflow;
    logic [PORT_W-1:0]    rr_ptr, lock_id, start, hi_id, lo_id, arb_id, winner, pid;
    logic                 lock, lock_hold, found_hi, req_fire, pid_ok, err_set;
    req_t                 win_req;

    // A held grant survives only while the locked port still has an eligible request.
    assign lock_hold = lock & elig[lock_id];

    // Scan for the first eligible port at/after the start point, wrapping to the lowest.
    always_comb begin
        start    = (ARB_MODE != 0) ? rr_ptr : '0;
        hi_id    = '0;
        lo_id    = '0;
        found_hi = 1'b0;
        for (int p = REQ_PORTS - 1; p >= 0; p--) begin
            if (elig[p]) begin
                lo_id = PORT_W'(p);
                if (PORT_W'(p) >= start) begin
                    hi_id    = PORT_W'(p);
                    found_hi = 1'b1;
                end
            end
        end
        arb_id = found_hi ? hi_id : lo_id;
    end

    assign winner         = lock_hold ? lock_id : arb_id;
    assign o_l2_req_valid = |elig;
    assign req_fire       = o_l2_req_valid & i_l2_req_ready;

    // Steer the winning port's request fields downstream.
    always_comb begin
        win_req.cmd     = i_req_cmd[winner];
        win_req.addr    = i_req_addr[winner];
        win_req.tag     = i_req_tag[winner];
        win_req.data    = i_req_data[winner];
        win_req.byte_en = i_req_byte_en[winner];
    end

    assign o_l2_req_cmd     = win_req.cmd;
    assign o_l2_req_addr    = win_req.addr;
    assign o_l2_req_tag     = {winner, win_req.tag};
    assign o_l2_req_data    = win_req.data;
    assign o_l2_req_byte_en = win_req.byte_en;

    // Response side: the upper tag bits select the port; out-of-range ids are sunk.
    assign pid             = i_l2_resp_tag[TAG_W +: PORT_W];
    assign pid_ok          = ({1'b0, pid} < (PORT_W + 1)'(REQ_PORTS));
    assign o_l2_resp_ready = pid_ok ? i_resp_ready[pid] : 1'b1;
    assign o_resp_tag      = i_l2_resp_tag[TAG_W-1:0];
    assign o_resp_data     = i_l2_resp_data;

    genvar g;
    generate
        for (g = 0; g < REQ_PORTS; g++) begin : g_lane
            assign o_req_ready[g]  = req_fire & (winner == PORT_W'(g));
            assign o_resp_valid[g] = i_l2_resp_valid & pid_ok & (pid == PORT_W'(g));
            assign resp_hs[g]      = o_resp_valid[g] & i_resp_ready[g];

            msrh_l2_req_router_lane #(.MAX_OUTST(MAX_OUTST)) u_lane (
                .clk       (i_clk),
                .rst_n     (i_reset_n),
                .req_valid (i_req_valid[g]),
                .req_is_rd (i_req_cmd[g] == M_XRD),
                .req_accept(o_req_ready[g]),
                .resp_hs   (resp_hs[g]),
                .eligible  (elig[g]),
                .underflow (underflow[g])
            );
        end
    endgenerate

    assign err_set = (lock & ~i_req_valid[lock_id])
                   | (i_l2_resp_valid & ~pid_ok)
                   | (|underflow);

    // Round-robin pointer, grant lock under backpressure and sticky error flag.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rr_ptr  <= '0;
            lock    <= 1'b0;
            lock_id <= '0;
            o_err   <= 1'b0;
        end else begin
            if (req_fire) begin
                rr_ptr <= (winner == PORT_W'(REQ_PORTS - 1)) ? '0 : winner + PORT_W'(1);
            end
            lock <= o_l2_req_valid & ~i_l2_req_ready;
            if (o_l2_req_valid && !i_l2_req_ready) begin
                lock_id <= winner;
            end
            if (err_set) begin
                o_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_msrh_l2_req_router.sv
// Bench for msrh_l2_req_router: a fixed-priority and a round-robin instance share
// one stimulus; directed table, hand sequences, then random vs a reference model.
module tb_msrh_l2_req_router;
    localparam int N = 3;
    localparam int TW = 8;
    localparam int AW = 32;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0]             req_valid;
    logic [N-1:0][4:0]        req_cmd;
    logic [N-1:0][AW-1:0]     req_addr;
    logic [N-1:0][TW-1:0]     req_tag;
    logic [N-1:0][DW-1:0]     req_data;
    logic [N-1:0][DW/8-1:0]   req_be;
    logic [N-1:0]             resp_ready;
    logic                     l2_req_ready, l2_resp_valid;
    logic [TW+1:0]            l2_resp_tag;
    logic [DW-1:0]            l2_resp_data;

    logic [1:0][N-1:0]        req_ready, resp_valid;
    logic [1:0][TW-1:0]       resp_tag;
    logic [1:0][DW-1:0]       resp_data, l2_data;
    logic [1:0]               l2_req_valid, l2_resp_ready, err;
    logic [1:0][4:0]          l2_cmd;
    logic [1:0][AW-1:0]       l2_addr;
    logic [1:0][TW+1:0]       l2_tag;
    logic [1:0][DW/8-1:0]     l2_be;

    always #5 clk = ~clk;

    genvar gm;
    generate
        for (gm = 0; gm < 2; gm++) begin : g_dut
            msrh_l2_req_router #(
                .REQ_PORTS(N), .TAG_W(TW), .ADDR_W(AW), .DATA_W(DW),
                .ARB_MODE(gm), .MAX_OUTST(4)
            ) u_dut (
                .i_clk(clk), .i_reset_n(rst_n),
                .i_req_valid(req_valid), .i_req_cmd(req_cmd), .i_req_addr(req_addr),
                .i_req_tag(req_tag), .i_req_data(req_data), .i_req_byte_en(req_be),
                .o_req_ready(req_ready[gm]), .o_resp_valid(resp_valid[gm]),
                .o_resp_tag(resp_tag[gm]), .o_resp_data(resp_data[gm]),
                .i_resp_ready(resp_ready),
                .o_l2_req_valid(l2_req_valid[gm]), .o_l2_req_cmd(l2_cmd[gm]),
                .o_l2_req_addr(l2_addr[gm]), .o_l2_req_tag(l2_tag[gm]),
                .o_l2_req_data(l2_data[gm]), .o_l2_req_byte_en(l2_be[gm]),
                .i_l2_req_ready(l2_req_ready), .i_l2_resp_valid(l2_resp_valid),
                .i_l2_resp_tag(l2_resp_tag), .i_l2_resp_data(l2_resp_data),
                .o_l2_resp_ready(l2_resp_ready[gm]), .o_err(err[gm])
            );
        end
    endgenerate

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Grant checks for instance m against an expected winner (-1 = none).
    task automatic chk_win(input int m, input int win, input string nm);
        chk($sformatf("%s_m%0d_valid", nm, m), l2_req_valid[m], (win >= 0));
        chk($sformatf("%s_m%0d_ready", nm, m), req_ready[m],
            (win >= 0 && l2_req_ready) ? 3'(1 << win) : 3'b000);
        if (win >= 0)
            chk($sformatf("%s_m%0d_tag", nm, m), l2_tag[m], {2'(win), req_tag[win]});
    endtask

    task automatic set_req(input bit [2:0] v, input bit [2:0] rd, input bit rdy);
        req_valid = v;
        for (int p = 0; p < N; p++) req_cmd[p] = rd[p] ? 5'd0 : 5'd1;
        l2_req_ready = rdy;
    endtask

    task automatic set_resp(input bit v, input bit [1:0] pid, input bit [7:0] tag, input bit [2:0] rdy);
        l2_resp_valid = v;
        l2_resp_tag   = {pid, tag};
        resp_ready    = rdy;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_req(3'b000, 3'b000, 1'b0);
        set_resp(1'b0, 2'd0, 8'd0, 3'b000);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // ---------------- reference model ----------------
    int m_outst[2][N];
    int m_rr[2];
    bit m_lock[2];
    int m_lid[2];
    bit m_err[2];

    task automatic m_init();
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < N; p++) m_outst[m][p] = 0;
            m_rr[m] = 0; m_lock[m] = 0; m_lid[m] = 0; m_err[m] = 0;
        end
    endtask

    function automatic bit m_elig(input int m, input int p);
        return req_valid[p] && !(req_cmd[p] == 5'd0 && m_outst[m][p] >= 4);
    endfunction

    function automatic int m_win(input int m);
        if (m_lock[m] && m_elig(m, m_lid[m])) return m_lid[m];
        for (int k = 0; k < N; k++) begin
            int p = ((m == 1 ? m_rr[m] : 0) + k) % N;
            if (m_elig(m, p)) return p;
        end
        return -1;
    endfunction

    task automatic m_check(input int m);
        int w   = m_win(m);
        int pid = int'(l2_resp_tag[TW+1:TW]);
        chk_win(m, w, "rnd");
        if (w >= 0) begin
            chk($sformatf("rnd_m%0d_addr", m), l2_addr[m], req_addr[w]);
            chk($sformatf("rnd_m%0d_cmd", m), l2_cmd[m], req_cmd[w]);
            chk($sformatf("rnd_m%0d_data", m), l2_data[m], req_data[w]);
            chk($sformatf("rnd_m%0d_be", m), l2_be[m], req_be[w]);
        end
        chk($sformatf("rnd_m%0d_rvalid", m), resp_valid[m],
            (l2_resp_valid && pid < N) ? 3'(1 << pid) : 3'b000);
        chk($sformatf("rnd_m%0d_l2rrdy", m), l2_resp_ready[m], (pid < N) ? resp_ready[pid] : 1'b1);
        chk($sformatf("rnd_m%0d_rtag", m), resp_tag[m], l2_resp_tag[TW-1:0]);
        chk($sformatf("rnd_m%0d_rdata", m), resp_data[m], l2_resp_data);
        chk($sformatf("rnd_m%0d_err", m), err[m], m_err[m]);
    endtask

    task automatic m_update(input int m);
        int w   = m_win(m);
        int pid = int'(l2_resp_tag[TW+1:TW]);
        bit acc = (w >= 0) && l2_req_ready;
        if (m_lock[m] && !req_valid[m_lid[m]]) m_err[m] = 1;
        if (l2_resp_valid && pid >= N) m_err[m] = 1;
        for (int p = 0; p < N; p++) begin
            bit inc = acc && (w == p) && (req_cmd[p] == 5'd0);
            bit dec = l2_resp_valid && (pid == p) && resp_ready[p];
            if (dec && m_outst[m][p] == 0) m_err[m] = 1;
            if (inc && !dec) m_outst[m][p]++;
            else if (dec && !inc && m_outst[m][p] > 0) m_outst[m][p]--;
        end
        if (acc) m_rr[m] = (w + 1) % N;
        m_lock[m] = (w >= 0) && !l2_req_ready;
        if (m_lock[m]) m_lid[m] = w;
    endtask

    // ---------------- directed table (writes only) ----------------
    typedef struct {
        bit [2:0] v;
        bit       rdy;
        int       w0;
        int       w1;
        bit       e0;
        bit       e1;
    } vec_t;
    vec_t tbl[13];

    initial begin
        tbl[0]  = '{3'b111, 1'b1, 0, 0, 1'b0, 1'b0};
        tbl[1]  = '{3'b111, 1'b1, 0, 1, 1'b0, 1'b0};
        tbl[2]  = '{3'b111, 1'b1, 0, 2, 1'b0, 1'b0};
        tbl[3]  = '{3'b111, 1'b1, 0, 0, 1'b0, 1'b0};
        tbl[4]  = '{3'b110, 1'b1, 1, 1, 1'b0, 1'b0};
        tbl[5]  = '{3'b100, 1'b0, 2, 2, 1'b0, 1'b0};
        tbl[6]  = '{3'b100, 1'b0, 2, 2, 1'b0, 1'b0};
        tbl[7]  = '{3'b101, 1'b0, 2, 2, 1'b0, 1'b0};
        tbl[8]  = '{3'b101, 1'b1, 2, 2, 1'b0, 1'b0};
        tbl[9]  = '{3'b001, 1'b1, 0, 0, 1'b0, 1'b0};
        tbl[10] = '{3'b010, 1'b0, 1, 1, 1'b0, 1'b0};
        tbl[11] = '{3'b001, 1'b1, 0, 0, 1'b0, 1'b0};
        tbl[12] = '{3'b000, 1'b1, -1, -1, 1'b1, 1'b1};

        for (int p = 0; p < N; p++) begin
            req_tag[p]  = 8'h10 + 8'(p);
            req_addr[p] = 32'h1000 * (p + 1);
            req_data[p] = {32'hD00D0000, 32'(p)};
            req_be[p]   = 8'hFF;
        end
        l2_resp_data = 64'hCAFE_F00D_1234_5678;
        set_req(3'b000, 3'b000, 1'b1);
        set_resp(1'b1, 2'd0, 8'h33, 3'b111);
        rst_n = 1'b0;

        // Reset state: nothing requested, response valid still follows the L2 side.
        #3;
        for (int m = 0; m < 2; m++) begin
            chk_win(m, -1, "rst");
            chk($sformatf("rst_m%0d_err", m), err[m], 1'b0);
            chk($sformatf("rst_m%0d_rvalid", m), resp_valid[m], 3'b001);
        end
        set_resp(1'b0, 2'd0, 8'h00, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 13; i++) begin
            set_req(tbl[i].v, 3'b000, tbl[i].rdy);
            mid();
            chk_win(0, tbl[i].w0, $sformatf("tbl%0d", i));
            chk_win(1, tbl[i].w1, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_m0_err", i), err[0], tbl[i].e0);
            chk($sformatf("tbl%0d_m1_err", i), err[1], tbl[i].e1);
            step();
        end
        do_reset();

        // Outstanding cap on port 1: four reads pass, fifth blocks, writes still pass.
        for (int i = 0; i < 5; i++) begin
            set_req(3'b010, 3'b010, 1'b1);
            mid();
            for (int m = 0; m < 2; m++)
                chk($sformatf("cap%0d_m%0d", i, m), req_ready[m], (i < 4) ? 3'b010 : 3'b000);
            step();
        end
        set_req(3'b010, 3'b000, 1'b1);
        mid();
        for (int m = 0; m < 2; m++) chk($sformatf("cap_wr_m%0d", m), req_ready[m], 3'b010);
        step();
        set_req(3'b010, 3'b010, 1'b1);
        set_resp(1'b1, 2'd1, 8'd5, 3'b111);
        mid();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("cap_ret_m%0d_rdy", m), req_ready[m], 3'b000);
            chk($sformatf("cap_ret_m%0d_rvalid", m), resp_valid[m], 3'b010);
            chk($sformatf("cap_ret_m%0d_rtag", m), resp_tag[m], 8'd5);
        end
        step();
        set_resp(1'b0, 2'd0, 8'd0, 3'b000);
        mid();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("cap_after_m%0d", m), req_ready[m], 3'b010);
            chk($sformatf("cap_after_m%0d_err", m), err[m], 1'b0);
        end
        step();

        // Out-of-range port id: sunk, no upstream valid, error next edge.
        set_req(3'b000, 3'b000, 1'b1);
        set_resp(1'b1, 2'd3, 8'd7, 3'b000);
        mid();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("pid3_m%0d_rvalid", m), resp_valid[m], 3'b000);
            chk($sformatf("pid3_m%0d_l2rrdy", m), l2_resp_ready[m], 1'b1);
        end
        step();
        set_resp(1'b0, 2'd0, 8'd0, 3'b000);
        mid();
        for (int m = 0; m < 2; m++) chk($sformatf("pid3_m%0d_err", m), err[m], 1'b1);
        do_reset();

        // Response to an idle port: routed, error once it is taken.
        set_resp(1'b1, 2'd2, 8'd5, 3'b000);
        mid();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("idle_m%0d_rvalid", m), resp_valid[m], 3'b100);
            chk($sformatf("idle_m%0d_rtag", m), resp_tag[m], 8'd5);
            chk($sformatf("idle_m%0d_l2rrdy0", m), l2_resp_ready[m], 1'b0);
        end
        step();
        set_resp(1'b1, 2'd2, 8'd5, 3'b100);
        mid();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("idle_m%0d_err_pre", m), err[m], 1'b0);
            chk($sformatf("idle_m%0d_l2rrdy1", m), l2_resp_ready[m], 1'b1);
        end
        step();
        set_resp(1'b0, 2'd0, 8'd0, 3'b000);
        mid();
        for (int m = 0; m < 2; m++) chk($sformatf("idle_m%0d_err", m), err[m], 1'b1);
        do_reset();

        // Reset mid-operation: counters 2/1/0, lock on port 2, error set.
        set_req(3'b001, 3'b001, 1'b1); step();
        set_req(3'b001, 3'b001, 1'b1); step();
        set_req(3'b010, 3'b010, 1'b1); step();
        set_req(3'b100, 3'b000, 1'b0);
        set_resp(1'b1, 2'd3, 8'd0, 3'b000);
        step();
        set_resp(1'b0, 2'd0, 8'd0, 3'b000);
        set_req(3'b111, 3'b000, 1'b1);
        #1;
        for (int m = 0; m < 2; m++) begin
            chk_win(m, 2, "mid_lock");
            chk($sformatf("mid_m%0d_err", m), err[m], 1'b1);
        end
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk_win(m, 0, "mid_rst");
            chk($sformatf("mid_rst_m%0d_err", m), err[m], 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int m = 0; m < 2; m++) chk_win(m, 0, "post_rst");
        step();
        for (int i = 0; i < 5; i++) begin
            set_req(3'b001, 3'b001, 1'b1);
            mid();
            for (int m = 0; m < 2; m++)
                chk($sformatf("post_cap%0d_m%0d", i, m), req_ready[m], (i < 4) ? 3'b001 : 3'b000);
            step();
        end

        // Randomized run against the reference model, with periodic resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 200 == 0) begin
                do_reset();
                m_init();
            end
            req_valid = 3'($urandom);
            for (int p = 0; p < N; p++) begin
                req_cmd[p]  = ($urandom_range(0, 1) != 0) ? 5'd0 : 5'd1;
                req_addr[p] = $urandom;
                req_tag[p]  = 8'($urandom);
                req_data[p] = {$urandom, $urandom};
                req_be[p]   = 8'($urandom);
            end
            l2_req_ready  = ($urandom_range(0, 9) < 7);
            l2_resp_valid = ($urandom_range(0, 9) < 4);
            l2_resp_tag   = {($urandom_range(0, 31) == 0) ? 2'd3 : 2'($urandom_range(0, 2)), 8'($urandom)};
            l2_resp_data  = {$urandom, $urandom};
            resp_ready    = 3'($urandom);
            mid();
            for (int m = 0; m < 2; m++) begin
                m_check(m);
                m_update(m);
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/msrh_l2_req_router.md
# msrh_l2_req_router

Parametrised N-port request arbiter and response router between tile-side L2 masters (ICache, L1D, ELF loader, future PTW) and a single L2 port. It replaces the hard-coded priority mux in the top-level bench and adds:

- selectable fixed-priority or round-robin arbitration;
- grant locking under backpressure;
- port-ID tag extension for response routing;
- per-port outstanding-read limits.

The request path is combinational. Arbitration state, lock and counters are registered.

## Interface

Parameters:
- REQ_PORTS, 3: number of upstream masters (≥2). Port 0 has the highest fixed priority.
- TAG_W, msrh_lsu_pkg::L2_CMD_TAG_W: upstream tag width.
- ADDR_W, riscv_pkg::PADDR_W: address width.
- DATA_W, msrh_lsu_pkg::ICACHE_DATA_W: data width.
- ARB_MODE, 0: 0 = fixed priority, 1 = round-robin.
- MAX_OUTST, 4: maximum reads in flight per port (1..15).
- Derived PORT_W = $clog2(REQ_PORTS).

Ports:
- i_clk  in  1  clock. One clock domain.
- i_reset_n  in  1  reset; asynchronous, active-low.
- i_req_valid  in  [REQ_PORTS]  upstream request valid.
- i_req_cmd  in  msrh_lsu_pkg::mem_cmd_t [REQ_PORTS]  command (M_XRD / M_XWR).
- i_req_addr  in  ADDR_W [REQ_PORTS]  address.
- i_req_tag  in  TAG_W [REQ_PORTS]  tag.
- i_req_data  in  DATA_W [REQ_PORTS]  write data.
- i_req_byte_en  in  DATA_W/8 [REQ_PORTS]  byte enables.
- o_req_ready  out  [REQ_PORTS]  request accepted when valid & ready.
- o_resp_valid  out  [REQ_PORTS]  response valid, one-hot.
- o_resp_tag  out  TAG_W  response tag, broadcast to all ports.
- o_resp_data  out  DATA_W  response data, broadcast to all ports.
- i_resp_ready  in  [REQ_PORTS]  upstream response ready.
- o_l2_req_valid, o_l2_req_cmd, o_l2_req_addr, o_l2_req_data, o_l2_req_byte_en  out  downstream request.
- o_l2_req_tag  out  TAG_W+PORT_W  {port_id, upstream tag}.
- i_l2_req_ready  in  1  downstream ready.
- i_l2_resp_valid  in  1  downstream response valid.
- i_l2_resp_tag  in  TAG_W+PORT_W  downstream response tag.
- i_l2_resp_data  in  DATA_W  downstream response data.
- o_l2_resp_ready  out  1  downstream response ready.
- o_err  out  1  sticky protocol error.

## Operation

Eligibility and arbitration:
- Port p is eligible when i_req_valid[p] is high and it is not blocked.
- Port p is blocked when cmd = M_XRD and outst[p] == MAX_OUTST. Writes are never blocked.
- ARB_MODE 0: the lowest eligible index wins.
- ARB_MODE 1: the first eligible index at or after rr_ptr wins (modulo REQ_PORTS).

Downstream request:
- The winner's fields are driven downstream, with the tag extended as {PORT_W'(winner), i_req_tag}.
- o_l2_req_valid = any eligible port.
- o_req_ready[winner] = i_l2_req_ready. All other ports see o_req_ready = 0.

Grant lock:
- If o_l2_req_valid is high and i_l2_req_ready is low, set lock and store lock_id = winner.
- While locked, lock_id is the winner regardless of the other ports.
- The lock clears on the accepting handshake.
- Upstream must hold a valid request stable. If a locked port drops valid, clear the lock and set o_err.

Round-robin pointer:
- On each accepted request, rr_ptr ← (winner+1) mod REQ_PORTS.
- In ARB_MODE 0 the pointer is unused.

Outstanding counters (outst[p], 4 bits per port):
- Increment on an accepted M_XRD.
- Decrement on a response handshake to port p.
- Increment and decrement in the same cycle: value unchanged.

Response routing:
- pid = i_l2_resp_tag[TAG_W+:PORT_W].
- o_resp_valid[pid] = i_l2_resp_valid. o_resp_tag = low TAG_W bits.
- o_l2_resp_ready = i_resp_ready[pid].

Error cases (each sets o_err):
- pid ≥ REQ_PORTS: drop the response (o_l2_resp_ready = 1, no o_resp_valid), set o_err.
- Response to a port with outst = 0: route it, keep the counter at 0, set o_err.

Write behaviour: writes produce no response and do not touch the counters.

## Timing

- Request path: zero-cycle combinational from i_req_* and i_l2_req_ready to o_l2_req_* and o_req_ready.
- Response path: zero-cycle combinational.
- Lock, rr_ptr, counters and o_err update on the rising edge of i_clk.

Reset values (async assertion; all take effect immediately):
- State: rr_ptr=0, lock=0, lock_id=0, outst=0, o_err=0.
- Outputs: o_l2_req_valid=0 and o_req_ready=0 whenever all i_req_valid are low. o_resp_valid follows i_l2_resp_valid combinationally.

Reset behaviour:
- Reset mid-transaction discards in-flight accounting. Upstream masters are reset together with the router.
- Deassertion is synchronous to the system; the first arbitration happens in the first cycle after release.

Other timing rules:
- Throughput: one request per cycle when i_l2_req_ready is held high.
- rr_ptr wraps from REQ_PORTS-1 to 0.

## Test plan

- Fixed priority: ARB_MODE=0, ports 0/1/2 valid, ready=1 → accepted in order 0,0,0 while port 0 stays valid. Then drop port 0 → port 1 granted. o_l2_req_tag = {2'd1, tag}.
- Round-robin: ARB_MODE=1, all three valid continuously, ready=1 → grants 0,1,2,0,1,2. rr_ptr wraps 2→0.
- Backpressure lock: port 2 wins with ready=0 for 3 cycles, then port 0 raises valid → port 2 stays granted. Accepted when ready=1 on cycle 4; port 0 is served next.
- Outstanding limit: MAX_OUTST=4, port 1 issues 4 reads with no responses → 5th read blocked (o_req_ready[1]=0), port 1 writes still pass. Return one response with tag {1,x} → outst=3 and the read is accepted the next cycle.
- Response routing and errors:
  - tag {2'd2, 5} → only o_resp_valid[2]=1, o_resp_tag=5.
  - pid=3 with REQ_PORTS=3 → dropped, o_l2_resp_ready=1, o_err=1 next edge.
  - Response to idle port → o_err=1.
- Reset mid-operation: counters at 2/1/0 and lock held, assert i_reset_n=0 asynchronously → all state and o_err return to 0 immediately. After release, port 0 is granted first in both modes.
